// File: rtl/pit_pkg.sv
// Shared definitions for the PIT prescaler: default select width, counter width
// helper, and the count vector and divider-mode types.
package pit_pkg;

   localparam int PIT_PRE_SIZE = 4;

   // Counter width needed to reach the largest ratio 2^(2^pre_size - 1).
   function automatic int pre_cnt_width(input int pre_size);
      return int'((32'd1 << pre_size) - 32'd1);
   endfunction

   typedef logic [pre_cnt_width(PIT_PRE_SIZE)-1:0] pre_cnt_t;

   typedef enum logic [1:0] {
      PRE_IDLE  = 2'b00,
      PRE_COUNT = 2'b01,
      PRE_WRAP  = 2'b10
   } pre_mode_e;

endpackage

// File: rtl/pit_sync_sel.sv
// Chooses the counter enable source (local or master PIT) and registers it as
// counter_sync, which is also forwarded unchanged to slave PITs.
module pit_sync_sel (
   input  logic bus_clk,
   input  logic async_rst_b,
   input  logic sync_reset,
   input  logic pit_ena,
   input  logic pit_slave,
   input  logic ext_sync_i,
   output logic counter_sync,
   output logic ext_sync_o
);

   logic src_s;
   logic sync_nxt_s;
   logic sync_r;

   // Source mux and sync-reset gating of the next enable value.
   always_comb begin
      src_s      = 1'b0;
      sync_nxt_s = 1'b0;
      if (pit_slave) begin
         src_s = ext_sync_i;
      end else begin
         src_s = pit_ena;
      end
      if (sync_reset) begin
         sync_nxt_s = 1'b0;
      end else begin
         sync_nxt_s = src_s;
      end
   end

   // Enable register.
   always_ff @(posedge bus_clk or negedge async_rst_b) begin
      if (!async_rst_b) begin
         sync_r <= 1'b0;
      end else begin
         sync_r <= sync_nxt_s;
      end
   end

   assign counter_sync = sync_r;
   assign ext_sync_o   = sync_r;

endmodule

// File: rtl/pit_prescale.sv
// Power-of-two prescaler ahead of the PIT modulo counter: produces the one-cycle
// prescale_out strobe while counter_sync is held, with a shadowed divide select.
module pit_prescale
   import pit_pkg::*;
#(
   parameter int PRE_SIZE    = PIT_PRE_SIZE,
   parameter bit NO_PRESCALE = 1'b0
) (
   input  logic                bus_clk,
   input  logic                async_rst_b,
   input  logic                sync_reset,
   input  logic                pit_ena,
   input  logic                pit_slave,
   input  logic                ext_sync_i,
   input  logic [PRE_SIZE-1:0] pre_sel,
   output logic                counter_sync,
   output logic                prescale_out,
   output logic                ext_sync_o,
   output logic [PRE_SIZE-1:0] pre_sel_act
);

   localparam int CNT_W = pre_cnt_width(PRE_SIZE);

   logic [CNT_W-1:0]    cnt_r;
   logic [CNT_W-1:0]    cnt_nxt_s;
   logic [CNT_W:0]      div_full_s;
   logic [CNT_W-1:0]    div_m1_s;
   logic                pout_r;
   logic                pout_nxt_s;
   logic [PRE_SIZE-1:0] act_r;
   logic [PRE_SIZE-1:0] act_nxt_s;
   logic [PRE_SIZE-1:0] sel_in_s;
   pre_mode_e           mode_s;

   pit_sync_sel u_sync_sel (
      .bus_clk      (bus_clk),
      .async_rst_b  (async_rst_b),
      .sync_reset   (sync_reset),
      .pit_ena      (pit_ena),
      .pit_slave    (pit_slave),
      .ext_sync_i   (ext_sync_i),
      .counter_sync (counter_sync),
      .ext_sync_o   (ext_sync_o)
   );

   // Terminal count; the shift is one bit wider so 1 << CNT_W is not lost.
   always_comb begin
      div_full_s = ((CNT_W + 1)'(1'b1) << act_r) - (CNT_W + 1)'(1'b1);
      div_m1_s   = div_full_s[CNT_W-1:0];
      if (NO_PRESCALE) begin
         sel_in_s = {PRE_SIZE{1'b0}};
      end else begin
         sel_in_s = pre_sel;
      end
   end

   // Divider mode decode; sync_reset takes priority over a wrap.
   always_comb begin
      mode_s = PRE_IDLE;
      if (!counter_sync || sync_reset) begin
         mode_s = PRE_IDLE;
      end else if (cnt_r == div_m1_s) begin
         mode_s = PRE_WRAP;
      end else begin
         mode_s = PRE_COUNT;
      end
   end

   // Next count, strobe and shadow select.
   always_comb begin
      cnt_nxt_s  = {CNT_W{1'b0}};
      pout_nxt_s = 1'b0;
      act_nxt_s  = act_r;
      case (mode_s)
         PRE_IDLE: begin
            cnt_nxt_s  = {CNT_W{1'b0}};
            pout_nxt_s = 1'b0;
            act_nxt_s  = sel_in_s;
         end
         PRE_COUNT: begin
            cnt_nxt_s  = cnt_r + CNT_W'(1'b1);
            pout_nxt_s = 1'b0;
            act_nxt_s  = act_r;
         end
         PRE_WRAP: begin
            cnt_nxt_s  = {CNT_W{1'b0}};
            pout_nxt_s = 1'b1;
            act_nxt_s  = sel_in_s;
         end
         default: begin
            cnt_nxt_s  = {CNT_W{1'b0}};
            pout_nxt_s = 1'b0;
            act_nxt_s  = sel_in_s;
         end
      endcase
   end

   // Divider state registers.
   always_ff @(posedge bus_clk or negedge async_rst_b) begin
      if (!async_rst_b) begin
         cnt_r  <= {CNT_W{1'b0}};
         pout_r <= 1'b0;
         act_r  <= {PRE_SIZE{1'b0}};
      end else begin
         cnt_r  <= cnt_nxt_s;
         pout_r <= pout_nxt_s;
         act_r  <= act_nxt_s;
      end
   end

   assign prescale_out = pout_r;
   assign pre_sel_act  = act_r;

endmodule

// File: tb/tb_pit_prescale.sv
// Self-checking bench for pit_prescale: directed scenarios plus random stimulus
// against a cycle-level reference model of the prescaler rules.
module tb_pit_prescale;

   logic       bus_clk;
   logic       async_rst_b;
   logic       sync_reset;
   logic       pit_ena;
   logic       pit_slave;
   logic       ext_sync_i;
   logic [3:0] pre_sel;
   logic       counter_sync;
   logic       prescale_out;
   logic       ext_sync_o;
   logic [3:0] pre_sel_act;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic m_cs;
   logic m_pout;
   int   m_act;
   int   m_el;

   pit_prescale dut (
      .bus_clk      (bus_clk),
      .async_rst_b  (async_rst_b),
      .sync_reset   (sync_reset),
      .pit_ena      (pit_ena),
      .pit_slave    (pit_slave),
      .ext_sync_i   (ext_sync_i),
      .pre_sel      (pre_sel),
      .counter_sync (counter_sync),
      .prescale_out (prescale_out),
      .ext_sync_o   (ext_sync_o),
      .pre_sel_act  (pre_sel_act)
   );

   initial bus_clk = 1'b0;
   always #5 bus_clk = ~bus_clk;

   task automatic model_reset();
      m_cs   = 1'b0;
      m_pout = 1'b0;
      m_act  = 0;
      m_el   = 0;
   endtask

   // Advance one clock: update the model from pre-edge inputs, then settle.
   task automatic step();
      logic src;
      logic cs_n;
      src  = pit_slave ? ext_sync_i : pit_ena;
      cs_n = src && !sync_reset;
      if (!async_rst_b) begin
         model_reset();
      end else begin
         if (!m_cs || sync_reset) begin
            m_el   = 0;
            m_pout = 1'b0;
            m_act  = int'(pre_sel);
         end else begin
            m_el = m_el + 1;
            if (m_el == (1 << m_act)) begin
               m_el   = 0;
               m_pout = 1'b1;
               m_act  = int'(pre_sel);
            end else begin
               m_pout = 1'b0;
            end
         end
         m_cs = cs_n;
      end
      @(posedge bus_clk);
      #1;
   endtask

   task automatic go_idle();
      pit_ena    = 1'b0;
      pit_slave  = 1'b0;
      ext_sync_i = 1'b0;
      sync_reset = 1'b0;
      repeat (3) step();
   endtask

   task automatic test_reset();
      async_rst_b = 1'b0;
      sync_reset  = 1'b0;
      pit_ena     = 1'b1;
      pit_slave   = 1'b0;
      ext_sync_i  = 1'b0;
      pre_sel     = 4'd5;
      model_reset();
      repeat (2) step();
      total++; if (counter_sync !== 1'b0) begin bad++; $display("FAIL reset_cs got=%b exp=0", counter_sync); end
      total++; if (prescale_out !== 1'b0) begin bad++; $display("FAIL reset_pout got=%b exp=0", prescale_out); end
      total++; if (ext_sync_o !== 1'b0) begin bad++; $display("FAIL reset_ext got=%b exp=0", ext_sync_o); end
      total++; if (pre_sel_act !== 4'd0) begin bad++; $display("FAIL reset_act got=%0d exp=0", pre_sel_act); end
      pit_ena = 1'b0;
      #2 async_rst_b = 1'b1;
      step();
   endtask

   task automatic test_ratio1();
      pre_sel = 4'd0;
      go_idle();
      pit_ena = 1'b1;
      step();
      total++; if (counter_sync !== 1'b1) begin bad++; $display("FAIL r1_cs got=%b exp=1", counter_sync); end
      total++; if (prescale_out !== 1'b0) begin bad++; $display("FAIL r1_first got=%b exp=0", prescale_out); end
      for (int i = 1; i <= 6; i++) begin
         step();
         total++; if (prescale_out !== 1'b1) begin bad++; $display("FAIL r1_pout cyc=%0d got=%b exp=1", i, prescale_out); end
      end
   endtask

   task automatic test_div8();
      pre_sel = 4'd3;
      go_idle();
      pit_ena = 1'b1;
      step();
      for (int i = 1; i <= 24; i++) begin
         step();
         total++;
         if (prescale_out !== ((i % 8) == 0)) begin
            bad++; $display("FAIL div8 cyc=%0d got=%b exp=%b", i, prescale_out, (i % 8) == 0);
         end
      end
   endtask

   task automatic test_change_mid();
      logic [3:0] exp_act;
      pre_sel = 4'd2;
      go_idle();
      pit_ena = 1'b1;
      step();
      for (int i = 1; i <= 36; i++) begin
         if (i == 3) pre_sel = 4'd4;
         step();
         exp_act = (i < 4) ? 4'd2 : 4'd4;
         total++;
         if (prescale_out !== (i == 4 || i == 20 || i == 36)) begin
            bad++; $display("FAIL chg_pout cyc=%0d got=%b", i, prescale_out);
         end
         total++;
         if (pre_sel_act !== exp_act) begin
            bad++; $display("FAIL chg_act cyc=%0d got=%0d exp=%0d", i, pre_sel_act, exp_act);
         end
      end
   endtask

   task automatic test_disable_mid();
      pre_sel = 4'd4;
      go_idle();
      pit_ena = 1'b1;
      step();
      repeat (9) step();
      pit_ena = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         step();
         total++; if (prescale_out !== 1'b0) begin bad++; $display("FAIL dis_pout cyc=%0d got=%b exp=0", i, prescale_out); end
         if (i == 1) begin
            total++; if (counter_sync !== 1'b0) begin bad++; $display("FAIL dis_cs got=%b exp=0", counter_sync); end
         end
      end
      pit_ena = 1'b1;
      step();
      for (int i = 1; i <= 16; i++) begin
         step();
         total++;
         if (prescale_out !== (i == 16)) begin
            bad++; $display("FAIL reen_pout cyc=%0d got=%b exp=%b", i, prescale_out, i == 16);
         end
      end
   endtask

   task automatic test_slave();
      int strobes;
      logic prev_ext;
      strobes = 0;
      pre_sel = 4'd2;
      go_idle();
      pit_slave = 1'b1;
      prev_ext  = 1'b0;
      for (int i = 0; i < 30; i++) begin
         ext_sync_i = (i < 20);
         prev_ext = ext_sync_i;
         step();
         if (prescale_out) strobes++;
         total++; if (counter_sync !== prev_ext) begin bad++; $display("FAIL slv_cs cyc=%0d got=%b exp=%b", i, counter_sync, prev_ext); end
         total++; if (ext_sync_o !== counter_sync) begin bad++; $display("FAIL slv_ext cyc=%0d got=%b exp=%b", i, ext_sync_o, counter_sync); end
      end
      total++; if (strobes !== 5) begin bad++; $display("FAIL slv_strobes got=%0d exp=5", strobes); end
      ext_sync_i = 1'b0;
      pit_slave  = 1'b0;
   endtask

   task automatic test_srst_wrap();
      pre_sel = 4'd1;
      go_idle();
      pit_ena = 1'b1;
      step();
      step();
      sync_reset = 1'b1;
      step();
      total++; if (prescale_out !== 1'b0) begin bad++; $display("FAIL srst_pout got=%b exp=0", prescale_out); end
      total++; if (counter_sync !== 1'b0) begin bad++; $display("FAIL srst_cs got=%b exp=0", counter_sync); end
      sync_reset = 1'b0;
      step();
      total++; if (counter_sync !== 1'b1) begin bad++; $display("FAIL srst_recover got=%b exp=1", counter_sync); end
   endtask

   task automatic test_async_mid();
      pre_sel = 4'd3;
      go_idle();
      pit_ena = 1'b1;
      repeat (12) step();
      #2 async_rst_b = 1'b0;
      #1;
      model_reset();
      total++; if (counter_sync !== 1'b0) begin bad++; $display("FAIL arst_cs got=%b exp=0", counter_sync); end
      total++; if (ext_sync_o !== 1'b0) begin bad++; $display("FAIL arst_ext got=%b exp=0", ext_sync_o); end
      total++; if (prescale_out !== 1'b0) begin bad++; $display("FAIL arst_pout got=%b exp=0", prescale_out); end
      total++; if (pre_sel_act !== 4'd0) begin bad++; $display("FAIL arst_act got=%0d exp=0", pre_sel_act); end
      async_rst_b = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         step();
         total++; if (prescale_out !== m_pout) begin bad++; $display("FAIL arst_after cyc=%0d got=%b exp=%b", i, prescale_out, m_pout); end
      end
   endtask

   task automatic test_random();
      go_idle();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 3) pit_ena = ~pit_ena;
         if ($urandom_range(0, 99) < 2) pit_slave = ~pit_slave;
         if ($urandom_range(0, 99) < 3) ext_sync_i = ~ext_sync_i;
         sync_reset = ($urandom_range(0, 199) < 2);
         if ($urandom_range(0, 99) < 5) pre_sel = 4'($urandom_range(0, 5));
         step();
         total++; if (counter_sync !== m_cs) begin bad++; $display("FAIL rnd_cs cyc=%0d got=%b exp=%b", i, counter_sync, m_cs); end
         total++; if (ext_sync_o !== m_cs) begin bad++; $display("FAIL rnd_ext cyc=%0d got=%b exp=%b", i, ext_sync_o, m_cs); end
         total++; if (prescale_out !== m_pout) begin bad++; $display("FAIL rnd_pout cyc=%0d got=%b exp=%b", i, prescale_out, m_pout); end
         total++; if (int'(pre_sel_act) !== m_act) begin bad++; $display("FAIL rnd_act cyc=%0d got=%0d exp=%0d", i, pre_sel_act, m_act); end
      end
   endtask

   task automatic test_max_ratio();
      int first;
      first = -1;
      pre_sel = 4'd15;
      go_idle();
      pit_ena = 1'b1;
      step();
      for (int i = 1; i <= 32770; i++) begin
         step();
         if (prescale_out && first < 0) first = i;
      end
      total++; if (first !== 32768) begin bad++; $display("FAIL max_first got=%0d exp=32768", first); end
      total++; if (pre_sel_act !== 4'd15) begin bad++; $display("FAIL max_act got=%0d exp=15", pre_sel_act); end
      pit_ena = 1'b0;
   endtask

   initial begin
      test_reset();
      test_ratio1();
      test_div8();
      test_change_mid();
      test_disable_mid();
      test_slave();
      test_srst_wrap();
      test_async_mid();
      test_random();
      test_max_ratio();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pit_prescale.md
Name: pit_prescale

Overview:
Prescaler and counter-enable stage that sits directly upstream of the PIT modulo counter. It generates the one-cycle `prescale_out` increment strobe at a programmable power-of-two division of `bus_clk`, and the `counter_sync` enable. `counter_sync` comes from the local enable (master mode) or from an external sync line (slave mode). It also re-exports the sync so that several PIT instances can start in lockstep.

Parameters:
- PRE_SIZE, 4, width of the divide select. Divide ratio is 2^pre_sel; counter width is 2^PRE_SIZE-1 bits (default max ratio 32768).
- NO_PRESCALE, 0, when 1 the shadow select is forced to 0, giving divide-by-1 permanently.

Ports:
- bus_clk  input  1  reference clock
- async_rst_b  input  1  asynchronous active-low reset
- sync_reset  input  1  synchronous reset; clears counter, strobe and sync
- pit_ena  input  1  local counter enable (master mode source)
- pit_slave  input  1  1 = take sync from ext_sync_i; 0 = take sync from pit_ena
- ext_sync_i  input  1  sync from master PIT, same clock domain
- pre_sel  input  PRE_SIZE  divide select; ratio = 2^pre_sel
- counter_sync  output  1  registered counter enable to the modulo counter
- prescale_out  output  1  one-cycle increment strobe
- ext_sync_o  output  1  equals counter_sync; drives slave PITs
- pre_sel_act  output  PRE_SIZE  currently active (shadow) divide select

Behaviour:
- Reset: `async_rst_b` is asynchronous and active-low; clock is `bus_clk`. On reset, `counter_sync`, `prescale_out`, `ext_sync_o` and the internal count are all 0, and `pre_sel_act` is 0.
- Sync source: `src = pit_slave ? ext_sync_i : pit_ena`.
  - `counter_sync <= src && !sync_reset` (1-cycle latency).
  - `ext_sync_o` is `counter_sync` itself, with no extra delay.
- Idle (`counter_sync` = 0, or `sync_reset` = 1): count <= 0, `prescale_out` <= 0, `pre_sel_act` <= `pre_sel` (or 0 if NO_PRESCALE).
- Counting (`counter_sync` = 1, `sync_reset` = 0):
  - div_m1 = (1 << `pre_sel_act`) - 1, computed at full counter width.
  - If count == div_m1: count <= 0, `prescale_out` <= 1, `pre_sel_act` <= `pre_sel`. A new ratio takes effect only at a period boundary.
  - Otherwise: count <= count + 1, `prescale_out` <= 0.
- Timing: if `counter_sync` first reads 1 in cycle T, the first `prescale_out` is high in cycle T+2^`pre_sel_act`, then every 2^`pre_sel_act` cycles. Each pulse is exactly one cycle wide, except at ratio 1.
- Ratio 1 (`pre_sel_act` = 0): `prescale_out` is high every cycle from T+1 while `counter_sync` is held.
- Disable mid-period: `counter_sync` falls on the next edge, count clears, and the partial period is discarded with no pulse. The next enable restarts a full period.
- `pre_sel` change while idle: latched continuously, so it applies from the first period.
- `pre_sel` change mid-period: ignored until the wrap. `pre_sel_act` updates in the same cycle `prescale_out` rises.
- `sync_reset` together with a wrap: `sync_reset` wins; no strobe is produced.
- Mode switch (`pit_slave` toggles) while running: the new source is sampled on the next edge. There is no count clear unless the new source is 0.
- Max ratio: count reaches 2^(2^PRE_SIZE-1)-1 with no overflow. Arithmetic is unsigned at counter width; the shift must not truncate.
- Async reset mid-period: all state returns to reset values immediately.

Decomposition:
- Shared package `pit_pkg`:
  - PRE_SIZE default constant.
  - Function `pre_cnt_width(PRE_SIZE)` returning 2^PRE_SIZE-1.
  - Typedef for the prescale count vector.
- Optional sub-module `pit_sync_sel`: source mux, `counter_sync` register and `ext_sync_o`.
- Divider logic stays in `pit_prescale`.

Test Plan:
- Reset, then `pit_ena`=1, `pre_sel`=0 -> `counter_sync` high the next cycle; `prescale_out` high every cycle from the following cycle.
- `pre_sel`=3, `pit_ena`=1 -> first `prescale_out` 8 cycles after `counter_sync` rises, then every 8 cycles, each 1 cycle wide.
- Running at `pre_sel`=2, change to 4 mid-period -> the current 4-cycle period completes; next pulses are 16 apart; `pre_sel_act` becomes 4 on the pulse cycle.
- `pre_sel`=4, drop `pit_ena` at count 9 -> no pulse; re-enable gives the first pulse a full 16 cycles later.
- `pit_slave`=1, `pit_ena`=0, `ext_sync_i` pulsed high for 20 cycles with `pre_sel`=2 -> `counter_sync`/`ext_sync_o` follow with 1-cycle lag; 5 strobes occur.
- `sync_reset` asserted in the exact wrap cycle at `pre_sel`=1 -> no strobe; `counter_sync`=0 the next cycle; `async_rst_b` low mid-period clears all outputs immediately.
